linebuffer_3x3_seq: RTL

LINEBUFFER_3X3_SEQ -- requirements
Module: linebuffer_3x3_seq

---
 rtl/linebuffer_3x3_seq_pkg.sv | 41 ++++
 rtl/linebuffer_3x3_seq_pos_cnt.sv | 59 +++++
 rtl/linebuffer_3x3_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/linebuffer_3x3_seq_pkg.sv
// Shared types and constants for the 3x3 line-buffer sequencer.
// Holds the state encoding, the sel codes and the row-width lookup.
package linebuffer_3x3_seq_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } lb_state_e;

  localparam logic [2:0] SEL_W16  = 3'd0;
  localparam logic [2:0] SEL_W14  = 3'd1;
  localparam logic [2:0] SEL_W28  = 3'd2;
  localparam logic [2:0] SEL_W56  = 3'd3;
  localparam logic [2:0] SEL_W112 = 3'd4;
  localparam logic [2:0] SEL_W224 = 3'd5;

  function automatic logic lb_sel_ok(input logic [2:0] sel);
    return (sel <= SEL_W224);
  endfunction

  // len_tbl packs the six row widths, sel code 0 in the least significant byte.
  function automatic logic [CNT_W-1:0] lb_width(input logic [2:0] sel,
                                                input logic [6*CNT_W-1:0] len_tbl);
    logic [CNT_W-1:0] w;
    case (sel)
      SEL_W16:  w = len_tbl[0*CNT_W +: CNT_W];
      SEL_W14:  w = len_tbl[1*CNT_W +: CNT_W];
      SEL_W28:  w = len_tbl[2*CNT_W +: CNT_W];
      SEL_W56:  w = len_tbl[3*CNT_W +: CNT_W];
      SEL_W112: w = len_tbl[4*CNT_W +: CNT_W];
      SEL_W224: w = len_tbl[5*CNT_W +: CNT_W];
      default:  w = len_tbl[0*CNT_W +: CNT_W];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/linebuffer_3x3_seq_pos_cnt.sv
// Row/column position of the next pixel in a W x W feature map.
// Clear has priority over advance; last_o flags the final pixel.
module linebuffer_3x3_pos_cnt
  import linebuffer_3x3_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [CNT_W-1:0] width_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic             last_o
);

  logic [CNT_W-1:0] row_q;
  logic [CNT_W-1:0] row_d;
  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] col_d;
  logic             col_end_s;
  logic             row_end_s;

  assign col_end_s = (col_q == (width_i - 8'd1));
  assign row_end_s = (row_q == (width_i - 8'd1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = 8'd0;
      col_d = 8'd0;
    end else if (adv_i) begin
      if (col_end_s) begin
        col_d = 8'd0;
        row_d = row_end_s ? 8'd0 : (row_q + 8'd1);
      end else begin
        col_d = col_q + 8'd1;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= 8'd0;
      col_q <= 8'd0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = row_end_s & col_end_s;

endmodule

// File: rtl/linebuffer_3x3_seq.sv
// Sequencer for eight 3x3 line buffers: accepts one W x W pass per start,
// drives the shift enable and reports the centre of every complete window.
module linebuffer_3x3_seq
  import linebuffer_3x3_seq_pkg::*;
#(
  parameter int LEN1 = 16,
  parameter int LEN2 = 14,
  parameter int LEN3 = 28,
  parameter int LEN4 = 56,
  parameter int LEN5 = 112,
  parameter int LEN6 = 224
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       cfg_sel_i,
  input  logic             abort_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic             shift_en_o,
  output logic [2:0]       sel_o,
  output logic             win_valid_o,
  output logic [CNT_W-1:0] win_row_o,
  output logic [CNT_W-1:0] win_col_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             cfg_err_o
);

  localparam logic [6*CNT_W-1:0] LEN_TBL = {CNT_W'(LEN6), CNT_W'(LEN5), CNT_W'(LEN4),
                                            CNT_W'(LEN3), CNT_W'(LEN2), CNT_W'(LEN1)};

  lb_state_e        state_q;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] width_q;
  logic             win_valid_q;
  logic [CNT_W-1:0] win_row_q;
  logic [CNT_W-1:0] win_col_q;
  logic             done_q;
  logic             cfg_err_q;

  logic             in_ready_s;
  logic             shift_s;
  logic             start_ok_s;
  logic             cnt_clr_s;
  logic             win_hit_s;
  logic [CNT_W-1:0] row_s;
  logic [CNT_W-1:0] col_s;
  logic             last_s;

  assign in_ready_s = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign shift_s    = in_valid_i & in_ready_s;
  assign start_ok_s = (state_q == ST_IDLE) & start_i & ~abort_i & lb_sel_ok(cfg_sel_i);
  assign cnt_clr_s  = start_ok_s | abort_i;
  // Only pixels at col>=2 close a window, so no window wraps across a row boundary.
  assign win_hit_s  = (row_s >= 8'd2) && (col_s >= 8'd2);

  linebuffer_3x3_pos_cnt u_pos_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr_s),
    .adv_i   (shift_s),
    .width_i (width_q),
    .row_o   (row_s),
    .col_o   (col_s),
    .last_o  (last_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_W16;
      width_q     <= CNT_W'(LEN1);
      win_valid_q <= 1'b0;
      win_row_q   <= 8'd0;
      win_col_q   <= 8'd0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      win_valid_q <= 1'b0;
      win_row_q   <= 8'd0;
      win_col_q   <= 8'd0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (start_i) begin
            if (lb_sel_ok(cfg_sel_i)) begin
              sel_q   <= cfg_sel_i;
              width_q <= lb_width(cfg_sel_i, LEN_TBL);
              state_q <= ST_FILL;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_FILL, ST_STREAM: begin
          // Abort beats everything, including the final pixel's window and done.
          if (abort_i) begin
            state_q <= ST_IDLE;
          end else if (shift_s) begin
            if (win_hit_s) begin
              win_valid_q <= 1'b1;
              win_row_q   <= row_s - 8'd1;
              win_col_q   <= col_s - 8'd1;
            end
            if (last_s) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if ((state_q == ST_FILL) && win_hit_s) begin
              state_q <= ST_STREAM;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_s;
  assign shift_en_o  = shift_s;
  assign sel_o       = sel_q;
  assign win_valid_o = win_valid_q;
  assign win_row_o   = win_row_q;
  assign win_col_o   = win_col_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign cfg_err_o   = cfg_err_q;

endmodule
